// File: rtl/float_stream_tx_pkg.sv
// Shared types for the float_24_8 stream transmitter: the sample word and the
// frame FSM state encoding.
package float_stream_tx_pkg;

  typedef logic [31:0] float_24_8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } float_stream_tx_state_t;

endpackage

// File: rtl/float_stream_tx_fifo.sv
// Small synchronous FIFO for float_24_8 words; registered storage with the
// read word presented combinationally from the read pointer.
module float_stream_fifo
  import float_stream_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  float_24_8        push_data,
  input  logic             pop,
  output float_24_8        pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  float_24_8        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/float_stream_tx.sv
// Frame transmitter: buffers written samples and emits fixed-length vld/fst/rdy
// frames. Define FLOAT_STREAM_TX_CNT_EN to add the frames_sent counter port.
module float_stream_tx
  import float_stream_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  float_24_8        wr_data,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output float_24_8        out_data,
  output logic             out_fst,
  output logic             out_vld,
  input  logic             out_rdy
`ifdef FLOAT_STREAM_TX_CNT_EN
  ,
  output logic [15:0]      frames_sent
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  float_stream_tx_state_t st_q, st_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic                   first_q, first_d;
  logic                   out_vld_q, out_vld_d;
  logic                   out_fst_q, out_fst_d;
  float_24_8              out_data_q, out_data_d;

  float_24_8              fifo_rd_data;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   load;
  logic                   xfer;
  logic                   last_xfer;
  logic                   accept_start;

  float_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (load),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_rdy       = (fifo_count != CNT_W'(DEPTH));
  assign fifo_push    = wr_vld && !fifo_full;
  assign accept_start = (st_q == IDLE) && start && (frame_len != '0);
  assign xfer         = out_vld_q && out_rdy;
  assign load         = (st_q == SEND) && (!out_vld_q || out_rdy) && !fifo_empty && (rem_q != '0);
  // rem_q counts loads, so once it is zero the word in the register is the last.
  assign last_xfer    = (st_q == SEND) && xfer && (rem_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (accept_start) st_d = SEND;
      SEND:    if (last_xfer) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (st_q == SEND) || (st_q == DONE);
    done = (st_q == DONE);
  end

  always_comb begin
    rem_d      = rem_q;
    first_d    = first_q;
    out_vld_d  = out_vld_q;
    out_fst_d  = out_fst_q;
    out_data_d = out_data_q;
    if (accept_start) begin
      rem_d   = frame_len;
      first_d = 1'b1;
    end
    if (load) begin
      out_vld_d  = 1'b1;
      out_fst_d  = first_q;
      out_data_d = fifo_rd_data;
      first_d    = 1'b0;
      rem_d      = rem_q - LEN_W'(1);
    end else if (xfer) begin
      out_vld_d = 1'b0;
      out_fst_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q      <= '0;
      first_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_fst_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      rem_q      <= rem_d;
      first_q    <= first_d;
      out_vld_q  <= out_vld_d;
      out_fst_q  <= out_fst_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_fst  = out_fst_q;
  assign out_data = out_data_q;

`ifdef FLOAT_STREAM_TX_CNT_EN
  logic [15:0] frames_q, frames_d;

  always_comb begin
    frames_d = frames_q;
    if (st_q == DONE) frames_d = frames_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frames_q <= '0;
    else        frames_q <= frames_d;
  end

  assign frames_sent = frames_q;
`endif

endmodule

// File: tb/tb_float_stream_tx.sv
// Directed self-checking bench for float_stream_tx; samples and drives on the
// falling clock edge so inputs set there are captured by the next rising edge.
module tb_float_stream_tx;
  import float_stream_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  float_24_8   wr_data;
  logic        wr_vld;
  logic        wr_rdy;
  logic [7:0]  frame_len;
  logic        start;
  logic        busy;
  logic        done;
  float_24_8   out_data;
  logic        out_fst;
  logic        out_vld;
  logic        out_rdy;
`ifdef FLOAT_STREAM_TX_CNT_EN
  logic [15:0] frames_sent;
`endif

  int n_checks = 0;
  int n_passed = 0;
  int exp_frames = 0;
  logic [31:0] got_q[$];
  logic        got_fst_q[$];
  logic [31:0] exp_q[$];
  int          n_done;

  always #5 clk = ~clk;

  float_stream_tx #(.DEPTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_vld    (wr_vld),
    .wr_rdy    (wr_rdy),
    .frame_len (frame_len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_data  (out_data),
    .out_fst   (out_fst),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy)
`ifdef FLOAT_STREAM_TX_CNT_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_data = w;
    wr_vld  = 1'b1;
    tick();
    wr_vld  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    frame_len = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic collect(input int budget);
    got_q.delete();
    got_fst_q.delete();
    n_done = 0;
    for (int c = 0; c < budget; c++) begin
      if (out_vld && out_rdy) begin
        got_q.push_back(out_data);
        got_fst_q.push_back(out_fst);
      end
      if (done) begin
        n_done++;
        break;
      end
      tick();
    end
  endtask

  task automatic check_frame(input string tag, input logic first_is_fst);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    chk({tag, "_done"}, n_done, 1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_f%0d", tag, i), got_fst_q[i], (i == 0) ? first_is_fst : 1'b0);
    end
  endtask

  task automatic chk_frames(input string tag);
`ifdef FLOAT_STREAM_TX_CNT_EN
    chk(tag, frames_sent, exp_frames);
`else
    n_checks = n_checks + 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_data = '0; wr_vld = 1'b0; frame_len = '0; start = 1'b0; out_rdy = 1'b1;
    repeat (2) tick();

    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_fst", out_fst, 0);
    chk("rst_out_data", out_data, 0);
    chk_frames("rst_frames");
    reset = 1'b1;
    tick();

    // Basic frame with exact cycle timing.
    exp_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    foreach (exp_q[i]) write_word(exp_q[i]);
    pulse_start(8'd4);
    chk("basic_busy_n1", busy, 1);
    chk("basic_vld_n1", out_vld, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_vld%0d", i), out_vld, 1);
      chk($sformatf("basic_data%0d", i), out_data, exp_q[i]);
      chk($sformatf("basic_fst%0d", i), out_fst, (i == 0) ? 1 : 0);
      tick();
    end
    chk("basic_done", done, 1);
    chk("basic_vld_end", out_vld, 0);
    tick();
    exp_frames++;
    chk("basic_done_clr", done, 0);
    chk("basic_busy_clr", busy, 0);
    chk_frames("basic_frames");

    // Backpressure: ready 1,0,0,1 across the three words.
    write_word(32'h41000000);
    write_word(32'h41100000);
    write_word(32'h41200000);
    pulse_start(8'd3);
    tick();
    chk("bp_a_data", out_data, 32'h41000000);
    chk("bp_a_fst", out_fst, 1);
    tick();
    chk("bp_b_data0", out_data, 32'h41100000);
    chk("bp_b_fst0", out_fst, 0);
    out_rdy = 1'b0;
    tick();
    chk("bp_b_data1", out_data, 32'h41100000);
    chk("bp_b_vld1", out_vld, 1);
    tick();
    chk("bp_b_data2", out_data, 32'h41100000);
    chk("bp_b_fst2", out_fst, 0);
    out_rdy = 1'b1;
    tick();
    chk("bp_c_data", out_data, 32'h41200000);
    chk("bp_c_vld", out_vld, 1);
    tick();
    chk("bp_done", done, 1);
    tick();
    exp_frames++;

    // Full FIFO: ninth word is refused until the first pop.
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("full_wr_rdy%0d", i), wr_rdy, (i < 8) ? 1 : 0);
      wr_data = 32'h42000000 + i;
      wr_vld  = 1'b1;
      if (i < 8) exp_q.push_back(32'h42000000 + i);
      tick();
    end
    pulse_start(8'd8);
    chk("full_wr_rdy_n1", wr_rdy, 0);
    wr_vld = 1'b0;
    tick();
    chk("full_wr_rdy_n2", wr_rdy, 1);
    collect(40);
    check_frame("full", 1'b1);
    tick();
    exp_frames++;

    // Underrun: frame resumes without re-asserting fst.
    write_word(32'h43000000);
    pulse_start(8'd3);
    tick();
    chk("ur_d0_vld", out_vld, 1);
    chk("ur_d0_data", out_data, 32'h43000000);
    chk("ur_d0_fst", out_fst, 1);
    tick();
    chk("ur_gap0_vld", out_vld, 0);
    wr_data = 32'h43100000; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    chk("ur_gap1_vld", out_vld, 0);
    tick();
    chk("ur_d1_vld", out_vld, 1);
    chk("ur_d1_data", out_data, 32'h43100000);
    chk("ur_d1_fst", out_fst, 0);
    wr_data = 32'h43200000; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    chk("ur_gap2_vld", out_vld, 0);
    chk("ur_gap2_busy", busy, 1);
    tick();
    chk("ur_d2_data", out_data, 32'h43200000);
    chk("ur_d2_fst", out_fst, 0);
    tick();
    chk("ur_done", done, 1);
    tick();
    exp_frames++;

    // Ignored starts: zero length, and a restart in the middle of a frame.
    frame_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_zero_busy0", busy, 0);
    tick();
    chk("ign_zero_busy1", busy, 0);
    write_word(32'h45000000);
    write_word(32'h45100000);
    write_word(32'h45200000);
    pulse_start(8'd3);
    tick();
    chk("ign_e0_data", out_data, 32'h45000000);
    chk("ign_e0_fst", out_fst, 1);
    frame_len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = '{32'h45100000, 32'h45200000};
    collect(20);
    check_frame("ign", 1'b0);
    tick();
    exp_frames++;
    chk("ign_busy_end", busy, 0);
    chk_frames("ign_frames");

    // Reset mid-frame after two of five words.
    for (int i = 0; i < 5; i++) write_word(32'h46000000 + i);
    pulse_start(8'd5);
    tick();
    chk("rmf_w0", out_data, 32'h46000000);
    tick();
    chk("rmf_w1", out_data, 32'h46000001);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rmf_out_vld", out_vld, 0);
    chk("rmf_out_fst", out_fst, 0);
    chk("rmf_out_data", out_data, 0);
    chk("rmf_busy", busy, 0);
    chk("rmf_done", done, 0);
    chk("rmf_wr_rdy", wr_rdy, 1);
    chk_frames("rmf_frames");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rmf_done_hold%0d", i), done, 0);
    end
    reset = 1'b1;
    tick();
    chk("rmf_post_done", done, 0);
    pulse_start(8'd1);
    chk("rmf_busy_n1", busy, 1);
    tick();
    chk("rmf_flushed_vld", out_vld, 0);
    write_word(32'h44000000);
    exp_q = '{32'h44000000};
    collect(20);
    check_frame("rmf_new", 1'b1);
    tick();
    exp_frames++;
    chk_frames("rmf_new_frames");

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
